ff_fifo_flex: RTL

FF_FIFO_FLEX -- requirements
Module: ff_fifo_flex

---
 rtl/ff_fifo_pkg.sv | 16 +
 rtl/ff_fifo_wrap_ctr.sv | 27 ++
 rtl/ff_fifo_flex.sv | 98 +++++++++
 3 files changed

// File: rtl/ff_fifo_pkg.sv
// Shared width helpers for the flexible-depth FIFO: ceil-log2 and the
// occupancy counter width, which must hold the full range 0..DEPTH.
package ff_fifo_pkg;

   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

   function automatic int lvl_w(input int depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ff_fifo_wrap_ctr.sv
// Modulo-MAX pointer counter: steps on inc, wraps MAX-1 -> 0 by compare,
// so MAX need not be a power of two.
module ff_fifo_wrap_ctr
   import ff_fifo_pkg::*;
#(
   parameter int MAX = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  inc,
   output logic [clog2(MAX)-1:0] cnt
);

   localparam int W = clog2(MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= (cnt == W'(MAX - 1)) ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/ff_fifo_flex.sv
// First-word-fall-through FIFO of arbitrary depth with an explicit level
// register, synchronous flush and registered almost-full/almost-empty flags.
module ff_fifo_flex
   import ff_fifo_pkg::*;
#(
   parameter  int D_WIDTH  = 8,
   parameter  int DEPTH    = 5,
   parameter  int AF_LEVEL = DEPTH - 1,
   parameter  int AE_LEVEL = 1,
   localparam int LVL_W    = lvl_w(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [D_WIDTH-1:0] up_data,
   input  logic               up_valid,
   output logic               up_ready,
   output logic [D_WIDTH-1:0] down_data,
   output logic               down_valid,
   input  logic               down_ready,
   output logic [LVL_W-1:0]   level,
   output logic               almost_full,
   output logic               almost_empty
);

   localparam int PTR_W = clog2(DEPTH);

   if (DEPTH < 2) begin : g_bad_depth
      $error("ff_fifo_flex: DEPTH must be 2 or more");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("ff_fifo_flex: AF_LEVEL must lie in 1..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("ff_fifo_flex: AE_LEVEL must lie in 0..DEPTH-1");
   end

   logic [D_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LVL_W-1:0]   level_nxt;
   logic               push;
   logic               pop;

   // Handshakes depend only on the level register, never on the far side.
   assign up_ready   = (level != LVL_W'(DEPTH)) & ~flush & ~rst;
   assign down_valid = (level != '0) & ~flush;
   assign push       = up_valid & up_ready;
   assign pop        = down_valid & down_ready;
   assign down_data  = mem[rd_ptr];

   ff_fifo_wrap_ctr #(.MAX(DEPTH)) u_wr_ctr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (push),
      .cnt (wr_ptr)
   );

   ff_fifo_wrap_ctr #(.MAX(DEPTH)) u_rd_ctr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (pop),
      .cnt (rd_ptr)
   );

   always_comb begin
      level_nxt = level;
      if (flush) begin
         level_nxt = '0;
      end else if (push && !pop) begin
         level_nxt = level + LVL_W'(1);
      end else if (pop && !push) begin
         level_nxt = level - LVL_W'(1);
      end
   end

   // Flags come from level_nxt so they line up with the level they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level        <= '0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         level        <= level_nxt;
         almost_full  <= (level_nxt >= LVL_W'(AF_LEVEL));
         almost_empty <= (level_nxt <= LVL_W'(AE_LEVEL));
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= up_data;
      end
   end

endmodule
